// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that multiplexes N_CH requesters onto one memory port.
//   One transaction is accepted per cycle.
//   Each accept is issued to memory on the next cycle.
//   The response returns to the issuing channel MEM_LAT cycles after issue.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/ready       per-channel handshake (ready is one-hot or zero)
//   req_addr/wdata/we     per-channel request payload, channel i at slice i
//   resp_valid            one-cycle pulse to the issuing channel
//   resp_rdata            shared read data (zero for write acks)
//   mem_addr/mem_data_i   registered memory address / write data
//   mem_data_en           registered memory access enable
//   mem_write_en          registered memory write enable
//   mem_data_o            memory read data, valid MEM_LAT cycles after enable
//
// Optional build macro
//   MEM_ARB_LOCK_EN adds a req_lock input.
//   A channel that is accepted with req_lock set owns the port.
//   It keeps the port until it is accepted with req_lock clear.
module mem_port_arbiter #(
  parameter int N_CH    = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  input  logic [N_CH-1:0]          req_we,
`ifdef MEM_ARB_LOCK_EN
  input  logic [N_CH-1:0]          req_lock,
`endif
  output logic [N_CH-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_i,
  input  logic [DATA_W-1:0]        mem_data_o,
  output logic                     mem_data_en,
  output logic                     mem_write_en
);

  localparam int CH_W = $clog2(N_CH);

  logic [CH_W-1:0] ptr;
  logic [N_CH-1:0] elig;
  logic            grant_any;
  logic [CH_W-1:0] grant_id;
  logic            ptr_adv;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  lock_state_t     lock_state;
  logic [CH_W-1:0] owner;

  // While locked, only the owner may compete for the port.
  always_comb begin
    elig = '0;
    if (rst_n) begin
      if (lock_state == LOCKED) elig[owner] = req_valid[owner];
      else                      elig = req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state <= UNLOCKED;
      owner      <= '0;
    end else if (grant_any) begin
      case (lock_state)
        UNLOCKED: if (req_lock[grant_id]) begin
          lock_state <= LOCKED;
          owner      <= grant_id;
        end
        LOCKED: if (!req_lock[grant_id]) lock_state <= UNLOCKED;
        default: lock_state <= UNLOCKED;
      endcase
    end
  end

  // The pointer stays put for the whole locked sequence.
  // It moves only on an accept that leaves the port unlocked.
  assign ptr_adv = grant_any && !req_lock[grant_id];
`else
  // Accepts in a reset cycle would be dropped, so no grant is offered then.
  assign elig    = rst_n ? req_valid : '0;
  assign ptr_adv = grant_any;
`endif

  // Search from ptr upward and wrap from N_CH-1 to 0.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_id  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= '0;
    else if (ptr_adv) ptr <= (grant_id == CH_W'(N_CH - 1)) ? '0 : grant_id + CH_W'(1);
  end

  // ---- p0: issue stage (accept -> memory port) ----
  logic            vld_p0;
  logic            we_p0;
  logic [CH_W-1:0] ch_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      we_p0      <= 1'b0;
      ch_p0      <= '0;
      mem_addr   <= '0;
      mem_data_i <= '0;
    end else begin
      vld_p0 <= grant_any;
      we_p0  <= grant_any && req_we[grant_id];
      if (grant_any) begin
        ch_p0      <= grant_id;
        mem_addr   <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        mem_data_i <= req_wdata[int'(grant_id)*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_data_en  = vld_p0;
  assign mem_write_en = we_p0;

  // ---- p1..pMEM_LAT: response tracking, aligned with memory read latency ----
  // Entry k holds the transaction that was issued k+1 cycles ago.
  logic            rvld_p [MEM_LAT];
  logic            rwe_p  [MEM_LAT];
  logic [CH_W-1:0] rch_p  [MEM_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        rvld_p[k] <= 1'b0;
        rwe_p[k]  <= 1'b0;
        rch_p[k]  <= '0;
      end
    end else begin
      rvld_p[0] <= vld_p0;
      rwe_p[0]  <= we_p0;
      rch_p[0]  <= ch_p0;
      for (int k = 1; k < MEM_LAT; k++) begin
        rvld_p[k] <= rvld_p[k-1];
        rwe_p[k]  <= rwe_p[k-1];
        rch_p[k]  <= rch_p[k-1];
      end
    end
  end

  // ---- response: memory data is valid in this same cycle ----
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (rvld_p[MEM_LAT-1]) begin
      resp_valid[rch_p[MEM_LAT-1]] = 1'b1;
      if (!rwe_p[MEM_LAT-1]) resp_rdata = mem_data_o;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_we, resp_valid;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic [31:0]  resp_rdata, mem_data_i, mem_data_o;
  logic [15:0]  mem_addr;
  logic         mem_data_en, mem_write_en;

  logic [3:0]   req_valid3, req_ready3, req_we3, resp_valid3;
  logic [63:0]  req_addr3;
  logic [127:0] req_wdata3;
  logic [31:0]  resp_rdata3, mem_data_i3, mem_data_o3;
  logic [15:0]  mem_addr3;
  logic         mem_data_en3, mem_write_en3;
`ifdef MEM_ARB_LOCK_EN
  logic [3:0]   req_lock, req_lock3;
`endif

  mem_port_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
`ifdef MEM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_data_en(mem_data_en),
    .mem_write_en(mem_write_en));

  mem_port_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_we(req_we3),
`ifdef MEM_ARB_LOCK_EN
    .req_lock(req_lock3),
`endif
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .mem_addr(mem_addr3),
    .mem_data_i(mem_data_i3), .mem_data_o(mem_data_o3), .mem_data_en(mem_data_en3),
    .mem_write_en(mem_write_en3));

  // Write-first synchronous memories: 1-cycle and 3-cycle read latency.
  logic [31:0] ram1 [0:255];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram1[i] <= '0;
      rd1 <= '0;
    end else if (mem_data_en) begin
      if (mem_write_en) ram1[mem_addr[9:2]] <= mem_data_i;
      rd1 <= mem_write_en ? mem_data_i : ram1[mem_addr[9:2]];
    end
  end
  assign mem_data_o = rd1;

  logic [31:0] ram3 [0:255];
  logic [31:0] rd3a, rd3b, rd3c;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram3[i] <= '0;
      rd3a <= '0; rd3b <= '0; rd3c <= '0;
    end else begin
      if (mem_data_en3) begin
        if (mem_write_en3) ram3[mem_addr3[9:2]] <= mem_data_i3;
        rd3a <= mem_write_en3 ? mem_data_i3 : ram3[mem_addr3[9:2]];
      end
      rd3b <= rd3a;
      rd3c <= rd3b;
    end
  end
  assign mem_data_o3 = rd3c;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] we;
    logic [3:0] exp_ready;
  } vec_t;

  exp_t        sb_q [$];
  logic [31:0] ref1 [0:255];
  vec_t        tbl  [20];
  logic [3:0]  l3_rdy [0:9];
  logic [3:0]  l3_rv  [0:9];
  logic [31:0] l3_rd  [0:9];
  int          cyc, checks, errors;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the MEM_LAT=1 instance.
  // Responses are checked first, then this cycle's accepts are recorded.
  task automatic mon();
    exp_t        e;
    logic [15:0] a;
    logic [31:0] d;
    if (resp_valid != 4'b0) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got valid=%b data=%h at cycle %0d, required none",
                 resp_valid, resp_rdata, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_resp {cycle,valid,data}", {32'(cyc), resp_valid, resp_rdata},
            {32'(e.due), 4'(1 << e.ch), e.data});
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      checks++; errors++;
      $display("FAIL resp_missing: ch%0d due at cycle %0d, absent at cycle %0d", e.ch, e.due, cyc);
    end
    if (!rst_n) begin
      sb_q.delete();
      for (int i = 0; i < 256; i++) ref1[i] = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          a = req_addr[c*16 +: 16];
          d = req_wdata[c*32 +: 32];
          e.ch  = c;
          e.due = cyc + 2;
          if (req_we[c]) begin
            ref1[a[9:2]] = d;
            e.data = '0;
          end else begin
            e.data = ref1[a[9:2]];
          end
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic we,
                        input logic [15:0] a, input logic [31:0] d);
    req_valid[ch] = v;
    req_we[ch]    = we;
    req_addr[ch*16 +: 16]  = a;
    req_wdata[ch*32 +: 32] = d;
  endtask

  task automatic set3(input int ch, input logic we, input logic [15:0] a, input logic [31:0] d);
    req_valid3[ch] = 1'b1;
    req_we3[ch]    = we;
    req_addr3[ch*16 +: 16]  = a;
    req_wdata3[ch*32 +: 32] = d;
  endtask

  logic prev_acc;

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0;
`ifdef MEM_ARB_LOCK_EN
    req_lock = '0; req_lock3 = '0;
`endif
    for (int i = 0; i < 256; i++) ref1[i] = '0;

    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[11] = '{4'b1001, 4'b0000, 4'b0001};
    tbl[12] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[13] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[14] = '{4'b0110, 4'b0010, 4'b0010};
    tbl[15] = '{4'b0110, 4'b0000, 4'b0100};
    tbl[16] = '{4'b0011, 4'b0000, 4'b0001};
    tbl[17] = '{4'b0011, 4'b0000, 4'b0010};
    tbl[18] = '{4'b0001, 4'b0000, 4'b0001};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000};

    l3_rdy = '{4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    l3_rv  = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0, 4'b0};
    l3_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11110010, 32'h22220014, 32'h0, 32'h0};

    // Reset, then idle
    repeat (3) begin sample(); adv(); end
    sample();
    chk("reset_outputs", {req_ready, resp_valid, mem_data_en, mem_write_en, mem_addr, mem_data_i, resp_rdata}, '0);
    rst_n = 1'b1;
    adv();
    for (int i = 0; i < 10; i++) begin
      sample();
      chk($sformatf("idle%0d_outputs", i),
          {req_ready, resp_valid, mem_data_en, mem_write_en, mem_addr, mem_data_i, resp_rdata}, '0);
      adv();
    end

    // Write ch1, then read-after-write from ch2
    set_ch(1, 1'b1, 1'b1, 16'h0040, 32'hDEADBEEF);
    sample(); chk("wr_ready", req_ready, 4'b0010);
    adv();
    set_ch(1, 1'b0, 1'b0, 16'h0, 32'h0);
    set_ch(2, 1'b1, 1'b0, 16'h0040, 32'h0);
    sample(); chk("rd_ready", req_ready, 4'b0100);
    chk("wr_issue", {mem_data_en, mem_write_en, mem_addr, mem_data_i}, {1'b1, 1'b1, 16'h0040, 32'hDEADBEEF});
    adv();
    set_ch(2, 1'b0, 1'b0, 16'h0, 32'h0);
    sample(); chk("rd_issue", {mem_data_en, mem_write_en, mem_addr}, {1'b1, 1'b0, 16'h0040});
    chk("wr_ack", {resp_valid, resp_rdata}, {4'b0010, 32'h0});
    adv();
    sample(); chk("rd_resp", {resp_valid, resp_rdata}, {4'b0100, 32'hDEADBEEF});
    chk("idle_hold", {mem_data_en, mem_write_en, mem_addr, mem_data_i}, {1'b0, 1'b0, 16'h0040, 32'h0});
    adv();

    // Reset with a read in flight: its response must never appear
    set_ch(3, 1'b1, 1'b0, 16'h0200, 32'h0);
    sample(); chk("pre_rst_ready", req_ready, 4'b1000);
    adv();
    set_ch(3, 1'b0, 1'b0, 16'h0, 32'h0);
    rst_n = 1'b0;
    sample(); adv();
    sample();
    rst_n = 1'b1;
    adv();
    for (int i = 0; i < 4; i++) begin
      sample(); chk($sformatf("no_resp_after_rst%0d", i), {resp_valid, mem_data_en}, '0);
      adv();
    end

    // Table-driven arbitration (pointer starts at 0 after reset)
    prev_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 4; c++)
        set_ch(c, tbl[i].valid[c], tbl[i].we[c], 16'h0200 + 16'(c*4), 32'hC0DE0000 | 32'(i*16 + c));
      sample();
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_en", i), mem_data_en, prev_acc);
      prev_acc = (tbl[i].exp_ready != 4'b0);
      adv();
    end
    req_valid = '0; req_we = '0;

`ifdef MEM_ARB_LOCK_EN
    // Pointer is 1 here; ch1 takes a lock while ch0/ch2 keep requesting
    set_ch(0, 1'b1, 1'b0, 16'h0300, 32'h0);
    set_ch(2, 1'b1, 1'b0, 16'h0308, 32'h0);
    set_ch(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    req_lock = 4'b0010;
    sample(); chk("lock_acquire", req_ready, 4'b0010);
    adv();
    set_ch(1, 1'b0, 1'b0, 16'h0020, 32'h0);
    req_lock = 4'b0000;
    sample(); chk("lock_blocks_others", req_ready, 4'b0000);
    adv();
    set_ch(1, 1'b1, 1'b1, 16'h0020, 32'h5A5A0001);
    sample(); chk("lock_release", req_ready, 4'b0010);
    adv();
    set_ch(1, 1'b0, 1'b0, 16'h0, 32'h0);
    sample(); chk("post_unlock", req_ready, 4'b0100);
    adv();
    sample(); chk("rr_resume", req_ready, 4'b0001);
    adv();
    req_valid = '0; req_we = '0;
`endif

    // MEM_LAT=3 instance: two writes, then back-to-back reads ch0 and ch3
    for (int k = 0; k < 10; k++) begin
      req_valid3 = '0; req_we3 = '0;
      case (k)
        0: set3(1, 1'b1, 16'h0010, 32'h11110010);
        1: set3(2, 1'b1, 16'h0014, 32'h22220014);
        2: set3(0, 1'b0, 16'h0010, 32'h0);
        3: set3(3, 1'b0, 16'h0014, 32'h0);
        default: ;
      endcase
      sample();
      chk($sformatf("lat3_k%0d_ready", k), req_ready3, l3_rdy[k]);
      chk($sformatf("lat3_k%0d_resp", k), {resp_valid3, resp_rdata3}, {l3_rv[k], l3_rd[k]});
      adv();
    end
    req_valid3 = '0;

    repeat (4) begin sample(); adv(); end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes requesters (core fetch, data cache, DMA) onto one port of the dual-port main memory.
- Round-robin grant, one transaction accepted per cycle.
- Fixed-latency read/write pipeline that routes each response back to the issuing channel.
- Instantiated at the psp top level between the caches and one memory port.

Parameters:
- N_CH, 4, number of requester channels (2..8).
- ADDR_W, 16, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from mem_data_en to valid mem_data_o (1..4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active low.
- req_valid  input  N_CH  per-channel request valid.
- req_ready  output  N_CH  per-channel accept; one-hot or zero.
- req_addr  input  N_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  N_CH*DATA_W  per-channel write data.
- req_we  input  N_CH  per-channel write enable (1=write, 0=read).
- resp_valid  output  N_CH  one-cycle response pulse to the issuing channel.
- resp_rdata  output  DATA_W  read data, shared by all channels; qualified by resp_valid.
- mem_addr  output  ADDR_W  memory address (registered).
- mem_data_i  output  DATA_W  memory write data (registered).
- mem_data_o  input  DATA_W  memory read data.
- mem_data_en  output  1  memory access enable (registered).
- mem_write_en  output  1  memory write enable (registered).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - req_ready, resp_valid, mem_data_en, mem_write_en = 0.
  - mem_addr, mem_data_i, resp_rdata = 0.
  - Round-robin pointer = 0.
  - Response pipeline cleared; in-flight transactions are dropped and never produce resp_valid after reset.
- Arbitration (combinational):
  - Grant goes to the first channel with req_valid=1, searching from pointer upward with wrap N_CH-1 -> 0.
  - req_ready is high for the granted channel only, and is 0 when no channel is valid.
  - req_ready depends on req_valid; this is the only combinational valid->ready path.
- Accept: req_valid[g] & req_ready[g] in cycle t.
  - Pointer <= (g+1) mod N_CH.
  - Non-accepting cycles leave the pointer unchanged.
- Issue:
  - In cycle t+1, mem_data_en=1, mem_write_en=req_we[g], mem_addr/mem_data_i = captured channel g values.
  - mem_data_en=0 in cycles with no accept.
  - mem_addr and mem_data_i hold their previous values when idle.
- Response pipeline:
  - Depth MEM_LAT shift register of {valid, channel id, we}.
  - In cycle t+1+MEM_LAT: resp_valid[g]=1 for exactly one cycle.
  - Reads: resp_rdata = mem_data_o.
  - Writes: resp_rdata = 0 (write ack).
  - Fixed total latency = 1+MEM_LAT cycles after accept for reads and writes.
- Throughput:
  - Back-to-back accepts every cycle, with no backpressure on responses.
  - Responses return in issue order.
- Simultaneous requests: exactly one grant per cycle; losers hold req_valid and address stable until accepted.
- Pointer wrap: after grant to N_CH-1, the search starts at 0.
- Single requester: granted every cycle regardless of pointer.
- Read-after-write to the same address from any channel returns the new data (memory is write-first; ordering is preserved by the single port).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (N_CH) and a two-state FSM UNLOCKED/LOCKED with owner register.
  - UNLOCKED -> LOCKED on accept with req_lock[g]=1 (owner=g).
  - In LOCKED, only the owner may be granted; other channels see req_ready=0.
  - LOCKED -> UNLOCKED on an owner accept with req_lock=0.
  - The pointer advances only on the unlocking accept.
  - Reset forces UNLOCKED.
  - Used for atomic read-modify-write sequences.
- Undefined: no req_lock port; pure round-robin as above.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; assert rst_n=0 with reads in flight -> no resp_valid after release.
- Write ch1 addr 0x0040 data 0xDEADBEEF at t=5, read ch2 addr 0x0040 at t=6 -> resp_valid[1] at t=7 with rdata 0, resp_valid[2] at t=8 with rdata 0xDEADBEEF.
- All 4 channels hold req_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3, with one accept per cycle and mem_data_en high for 8 consecutive cycles.
- MEM_LAT=3, back-to-back reads ch0 0x0010 then ch3 0x0014 -> resp_valid[0] 4 cycles after the first accept, resp_valid[3] 1 cycle later, with correct data.
- Pointer wrap: ch3 granted, then ch0 and ch3 both valid -> ch0 granted next.
- MEM_ARB_LOCK_EN: ch1 read lock=1 at addr 0x0020, ch0/ch2 valid throughout -> ch1 write lock=0 granted next; ch2 granted after unlock.
